// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned get_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = get_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               found
);

    // Pass one covers ptr..NUM_REQ-1, pass two wraps to 0..ptr-1.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IW'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream
// requesters, with packet locking and an idle-lock timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [7:0]           uart_data,
    output logic                 uart_send,
    input  logic                 uart_sent
);

    localparam int unsigned IW = get_width(NUM_REQ);
    localparam int unsigned CW = get_width(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_e           state_q, state_d;
    logic                 locked;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        rr_ptr;
    logic [CW-1:0]        lock_cnt;

    logic [NUM_REQ-1:0]   owner_oh;
    logic [NUM_REQ-1:0]   pick_req;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_found;
    logic [7:0]           sel_data;
    logic                 sel_last;
    logic                 owner_valid;
    logic                 accept_c;
    logic [IW-1:0]        next_ptr;

    // While locked only the owner may compete.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner == IW'(i));
        end
        pick_req    = locked ? (req_valid & owner_oh) : req_valid;
        owner_valid = |(req_valid & owner_oh);
    end

    uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Winner's byte and last flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_data = sel_data | req_data[8*i +: 8];
                sel_last = sel_last | req_last[i];
            end
        end
    end

    assign next_ptr = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (accept_c)  state_d = ARB_BUSY;
            ARB_BUSY: if (uart_sent) state_d = ARB_IDLE;
        endcase
    end

    // Ready is held low during reset even though the state reads IDLE.
    always_comb begin
        req_ready = '0;
        accept_c  = 1'b0;
        if (rst_n && (state_q == ARB_IDLE)) begin
            req_ready = pick_gnt;
            accept_c  = pick_found;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_data <= '0;
            uart_send <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            locked    <= 1'b0;
            owner     <= '0;
            rr_ptr    <= '0;
            lock_cnt  <= '0;
        end else begin
            busy <= (state_d == ARB_BUSY);
            if (accept_c) begin
                uart_data <= sel_data;
                uart_send <= 1'b1;
                grant     <= pick_gnt;
                owner     <= pick_idx;
                rr_ptr    <= next_ptr;
                locked    <= !sel_last;
                lock_cnt  <= '0;
            end else if ((state_q == ARB_BUSY) && uart_sent) begin
                uart_send <= 1'b0;
                lock_cnt  <= '0;
                if (!locked) grant <= '0;
            end else if ((state_q == ARB_IDLE) && locked && !owner_valid) begin
                // Idle owner: count toward releasing the lock, saturating.
                if ((LOCK_TIMEOUT != 0) && (lock_cnt == CNT_LAST)) begin
                    locked <= 1'b0;
                    grant  <= '0;
                end else if (lock_cnt != CNT_MAX) begin
                    lock_cnt <= lock_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written
// sequences for reset, fairness and lock timeout.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  grant;
    logic          busy;
    logic [7:0]    uart_data;
    logic          uart_send;
    logic          uart_sent;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        sent;
        logic [3:0]  e_ready;
        logic        e_send;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic [7:0]  e_data;
    } vec_t;

    vec_t tbl[$];

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .uart_data (uart_data),
        .uart_send (uart_send),
        .uart_sent (uart_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at negedge, check ready before the edge, registered outputs after.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        req_valid = v.valid;
        req_data  = v.data;
        req_last  = v.last;
        uart_sent = v.sent;
        #1 chk($sformatf("vec%0d ready", idx), 32'(req_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d send", idx),  32'(uart_send), 32'(v.e_send));
        chk($sformatf("vec%0d grant", idx), 32'(grant),     32'(v.e_grant));
        chk($sformatf("vec%0d busy", idx),  32'(busy),      32'(v.e_busy));
        chk($sformatf("vec%0d data", idx),  32'(uart_data), 32'(v.e_data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single byte from req 2, then a locked packet from req 1 with req 0 waiting.
        tbl.push_back('{4'b0100, 32'h005A0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h5A});
        tbl.push_back('{4'b0000, 32'h005A0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h5A});
        tbl.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h5A});
        tbl.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h5A});
        tbl.push_back('{4'b0010, 32'h00001000, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h10});
        tbl.push_back('{4'b0011, 32'h000011A0, 4'b0001, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h10});
        tbl.push_back('{4'b0011, 32'h000011A0, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0010, 1'b0, 8'h10});
        tbl.push_back('{4'b0011, 32'h000011A0, 4'b0001, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11});
        tbl.push_back('{4'b0011, 32'h000012A0, 4'b0011, 1'b1, 4'b0000, 1'b0, 4'b0010, 1'b0, 8'h11});
        tbl.push_back('{4'b0011, 32'h000012A0, 4'b0011, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h12});
        tbl.push_back('{4'b0001, 32'h000000A0, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h12});
        tbl.push_back('{4'b0001, 32'h000000A0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0});
        tbl.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA0});
        tbl.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA0});

        // Reset state, with requests pending to confirm ready stays low.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        req_last  = 4'b1111;
        uart_sent = 1'b0;
        #2;
        chk("reset ready", 32'(req_ready), 32'h0);
        chk("reset send",  32'(uart_send), 32'h0);
        chk("reset grant", 32'(grant),     32'h0);
        chk("reset busy",  32'(busy),      32'h0);
        chk("reset data",  32'(uart_data), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        req_last  = '0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Reset while a byte is in flight.
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h00007700;
        req_last  = 4'b0010;
        uart_sent = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst pre grant", 32'(grant), 32'h2);
        chk("midrst pre busy",  32'(busy),  32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst send",  32'(uart_send), 32'h0);
        chk("midrst grant", 32'(grant),     32'h0);
        chk("midrst busy",  32'(busy),      32'h0);
        chk("midrst data",  32'(uart_data), 32'h0);
        chk("midrst ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;

        // Fairness: all requesters always valid, restart from req 0 after reset.
        for (int k = 0; k < 8; k++) begin
            int w;
            logic [3:0] oh;
            w  = k % 4;
            oh = 4'b0001 << w;
            @(negedge clk);
            req_valid = 4'b1111;
            req_data  = 32'hD3D2D1D0;
            req_last  = 4'b1111;
            uart_sent = 1'b0;
            #1 chk($sformatf("fair%0d ready", k), 32'(req_ready), 32'(oh));
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d grant", k), 32'(grant),     32'(oh));
            chk($sformatf("fair%0d data", k),  32'(uart_data), 32'(8'(8'hD0 + w)));
            chk($sformatf("fair%0d send", k),  32'(uart_send), 32'h1);
            @(negedge clk);
            uart_sent = 1'b1;
            #1 chk($sformatf("fair%0d busy ready", k), 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d done send", k),  32'(uart_send), 32'h0);
            chk($sformatf("fair%0d done grant", k), 32'(grant),     32'h0);
        end

        // Lock timeout: req 3 locks then goes idle while req 0 waits.
        @(negedge clk);
        req_valid = 4'b1000;
        req_data  = 32'h33000000;
        req_last  = 4'b0000;
        uart_sent = 1'b0;
        #1 chk("tmo accept ready", 32'(req_ready), 32'h8);
        @(posedge clk);
        #1;
        chk("tmo accept grant", 32'(grant),     32'h8);
        chk("tmo accept data",  32'(uart_data), 32'h33);
        @(negedge clk);
        req_valid = 4'b0001;
        req_data  = 32'h000000A5;
        req_last  = 4'b0001;
        uart_sent = 1'b1;
        @(posedge clk);
        #1;
        chk("tmo idle busy",  32'(busy),  32'h0);
        chk("tmo idle grant", 32'(grant), 32'h8);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            uart_sent = 1'b0;
            #1 chk($sformatf("tmo%0d ready", k), 32'(req_ready), 32'h0);
            @(posedge clk);
            #1 chk($sformatf("tmo%0d grant", k), 32'(grant), (k < 8) ? 32'h8 : 32'h0);
        end
        @(negedge clk);
        #1 chk("tmo release ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("tmo release grant", 32'(grant),     32'h1);
        chk("tmo release data",  32'(uart_data), 32'hA5);
        chk("tmo release send",  32'(uart_send), 32'h1);
        @(negedge clk);
        req_valid = '0;
        uart_sent = 1'b1;
        @(posedge clk);
        #1;
        chk("tmo end send",  32'(uart_send), 32'h0);
        chk("tmo end grant", 32'(grant),     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
